pv_frame_scheduler: RTL and testbench
=====================================

# pv_frame_scheduler

Frame-level sequencer for the phase-vocoder pitch path. It sits between cart_to_polar, scaler and polar_to_cart. It accepts completed analysis frames, zero-fills the scaler's synthesis scratch buffers (synth mags/devs), latches a frame-stable scale amount, and launches scaler. It then forwards completion to polar_to_cart only when that stage is ready. A one-deep pending slot absorbs back-to-back frames; further frames are dropped and flagged.

## Interface
- NBINS, 2048, bins per frame / scratch-buffer depth
- ADDR_W, 12, scratch-buffer address width
- DATA_W, 16, scratch-buffer and scale width
- DEFAULT_SCALE, 16'h0100, substituted when the latched scale is zero

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- frame_valid  in  1  one-cycle pulse from cart_to_polar: frame complete
- frame_window  in  1  ping-pong buffer index of that frame
- scale_amt_in  in  DATA_W  live scale from software_interface
- scaler_go  out  1  one-cycle launch pulse to scaler
- scaler_window  out  1  buffer index for the scaler run
- scale_amt  out  DATA_W  frame-stable scale to scaler
- scaler_done  in  1  one-cycle completion pulse from scaler
- p2c_ready  in  1  level: polar_to_cart can accept a frame
- p2c_go  out  1  one-cycle launch pulse to polar_to_cart
- p2c_window  out  1  buffer index for polar_to_cart
- clr_wraddr  out  ADDR_W  scratch clear address (mags and devs)
- clr_wren  out  1  scratch clear write enable; write data is fixed 0
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: a frame was dropped
- spurious_done  out  1  sticky: scaler_done seen outside BUSY

## Operation
- States: IDLE, CLEAR, LAUNCH, BUSY, DRAIN.
- IDLE:
  - On frame_valid, or when pending is set: latch the window into cur_win.
  - Latch scale_amt_in into scale_amt, using DEFAULT_SCALE if the value is 0.
  - Clear pending, then go to CLEAR.
- CLEAR: clr_wren=1; clr_wraddr counts 0..NBINS-1, one address per cycle. After the write at NBINS-1, go to LAUNCH.
- LAUNCH: scaler_go=1 and scaler_window=cur_win for exactly one cycle, then go to BUSY.
- BUSY: wait for scaler_done.
  - If p2c_ready is high in the same cycle, pulse p2c_go next cycle with p2c_window=cur_win, then go to IDLE.
  - Otherwise go to DRAIN.
- DRAIN: hold until p2c_ready=1. Then pulse p2c_go for one cycle and go to IDLE.
- Pending slot:
  - A frame_valid outside IDLE while pending=0 sets pending and stores the window in pend_win.
  - A frame_valid while pending=1 is dropped: set overrun; the stored pend_win is kept.
  - IDLE consumes pend_win over a new frame_valid; a new frame_valid arriving in that same cycle is stored as pending.
- Simultaneous events in the cycle of exit to IDLE: a frame_valid in that cycle enters pending (it is not lost).
- scaler_done outside BUSY: ignored for sequencing; sets spurious_done.
- scale_amt and scaler_window are constant from LAUNCH until the next IDLE exit.
- Sticky flags clear only on reset.

## Timing
- Reset (reset_n=0 at a clk edge):
  - State becomes IDLE; pending=0.
  - All outputs go to 0, except scale_amt=DEFAULT_SCALE.
  - This applies mid-operation: clr_wren is 0 from the first reset cycle, and any in-flight run is abandoned with no p2c_go.
- With frame_valid at cycle 0 in IDLE:
  - clr_wren is high in cycles 1..NBINS, with addresses 0..NBINS-1.
  - scaler_go is high in cycle NBINS+1.
  - busy is high from cycle 1 through the p2c_go cycle.
- With scaler_done at cycle T and p2c_ready=1: p2c_go is high at T+1, and IDLE is reached at T+2.
- With a pending frame: the next CLEAR starts one cycle after IDLE is entered.
- All outputs are registered.

## Configuration
- PV_SCHED_STATS_EN defined:
  - Adds 16-bit saturating counters frames_done (increments on each p2c_go) and frames_dropped (increments on each overrun event).
  - Adds the output ports frames_done_cnt and frames_dropped_cnt.
  - Counters reset to 0.
- PV_SCHED_STATS_EN undefined: neither the counters nor their ports exist; all other behaviour is identical.

## Structure
- Shared package pv_pkg holds:
  - the state enum pv_sched_state_t;
  - constants PV_NBINS and PV_ADDR_W;
  - the default unity scale PV_UNITY_SCALE.
- One sub-module, pv_buf_clearer: a start/done address sweeper that drives clr_wraddr and clr_wren. Start pulses in IDLE; done is a one-cycle pulse on the last address.

## Test plan
- Single frame: frame_valid with window=1, scale_amt_in=16'h0180, p2c_ready=1, scaler_done 100 cycles after scaler_go.
  -> 2048 clear writes to addresses 0..2047; scaler_go at cycle 2049 with scaler_window=1 and scale_amt=16'h0180; p2c_go one cycle after scaler_done with p2c_window=1.
- Zero scale: scale_amt_in=0 -> scale_amt=16'h0100. Changing scale_amt_in during BUSY leaves scale_amt unchanged.
- Back-pressure: p2c_ready=0 at scaler_done, rises 50 cycles later -> DRAIN holds; a single p2c_go in the cycle after p2c_ready rises.
- Overrun: three frame_valid pulses (windows 0,1,0) 10 cycles apart.
  -> First frame runs; second becomes pending and runs next with window 1; third is dropped and overrun=1.
  -> With PV_SCHED_STATS_EN: frames_dropped_cnt=1 and frames_done_cnt=2.
- Reset at clear address 1000 -> clr_wren=0 immediately; no scaler_go. A later frame restarts the clear at address 0.
- Spurious done: scaler_done in IDLE -> spurious_done=1; state stays IDLE; no p2c_go.

Source files
------------

// File: rtl/pv_pkg.sv
// Shared constants and FSM encoding for the phase-vocoder frame scheduler.
package pv_pkg;

   localparam int          PV_NBINS       = 2048;
   localparam int          PV_ADDR_W      = 12;
   localparam logic [15:0] PV_UNITY_SCALE = 16'h0100;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_BUSY   = 3'd3,
      ST_DRAIN  = 3'd4
   } pv_sched_state_t;

   // Statistics counters stick at all-ones rather than wrapping
   function automatic logic [15:0] pv_sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pv_buf_clearer.sv
// Address sweeper that zero-fills the synth scratch buffers, one address per cycle.
module pv_buf_clearer
   import pv_pkg::*;
#(
   parameter int NBINS  = PV_NBINS,
   parameter int ADDR_W = PV_ADDR_W
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              done,
   output logic [ADDR_W-1:0] clr_wraddr,
   output logic              clr_wren
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NBINS - 1);

   // High during the write to the last address
   assign done = clr_wren && (clr_wraddr == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clr_wren   <= 1'b0;
         clr_wraddr <= '0;
      end else if (clr_wren) begin
         if (done) begin
            clr_wren   <= 1'b0;
            clr_wraddr <= '0;
         end else begin
            clr_wraddr <= clr_wraddr + 1'b1;
         end
      end else if (start) begin
         clr_wren   <= 1'b1;
         clr_wraddr <= '0;
      end
   end

endmodule

// File: rtl/pv_frame_scheduler.sv
// Frame sequencer: clear scratch -> launch scaler -> hand off to polar_to_cart.
// Define PV_SCHED_STATS_EN to add saturating frames_done / frames_dropped counters.
module pv_frame_scheduler
   import pv_pkg::*;
#(
   parameter int                NBINS         = PV_NBINS,
   parameter int                ADDR_W        = PV_ADDR_W,
   parameter int                DATA_W        = 16,
   parameter logic [DATA_W-1:0] DEFAULT_SCALE = DATA_W'(PV_UNITY_SCALE)
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_valid,
   input  logic              frame_window,
   input  logic [DATA_W-1:0] scale_amt_in,
   output logic              scaler_go,
   output logic              scaler_window,
   output logic [DATA_W-1:0] scale_amt,
   input  logic              scaler_done,
   input  logic              p2c_ready,
   output logic              p2c_go,
   output logic              p2c_window,
   output logic [ADDR_W-1:0] clr_wraddr,
   output logic              clr_wren,
   output logic              busy,
   output logic              overrun,
   output logic              spurious_done
`ifdef PV_SCHED_STATS_EN
   ,
   output logic [15:0]       frames_done_cnt,
   output logic [15:0]       frames_dropped_cnt
`endif
);

   pv_sched_state_t state, state_nxt;
   logic cur_win, pend_win, pending;
   logic clr_start, clr_done, drop, p2c_fire;

   assign clr_start = (state == ST_IDLE) && (frame_valid || pending);
   assign drop      = (state != ST_IDLE) && frame_valid && pending;
   // DRAIN is also the one-cycle p2c_go slot; leave once the pulse is out
   assign p2c_fire  = ((state == ST_BUSY) && scaler_done && p2c_ready) ||
                      ((state == ST_DRAIN) && !p2c_go && p2c_ready);

   pv_buf_clearer #(.NBINS(NBINS), .ADDR_W(ADDR_W)) u_clr (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (clr_start),
      .done      (clr_done),
      .clr_wraddr(clr_wraddr),
      .clr_wren  (clr_wren)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (clr_start)   state_nxt = ST_CLEAR;
         ST_CLEAR:  if (clr_done)    state_nxt = ST_LAUNCH;
         ST_LAUNCH:                  state_nxt = ST_BUSY;
         ST_BUSY:   if (scaler_done) state_nxt = ST_DRAIN;
         ST_DRAIN:  if (p2c_go)      state_nxt = ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         busy          <= 1'b0;
         cur_win       <= 1'b0;
         pend_win      <= 1'b0;
         pending       <= 1'b0;
         scaler_go     <= 1'b0;
         scaler_window <= 1'b0;
         scale_amt     <= DEFAULT_SCALE;
         p2c_go        <= 1'b0;
         p2c_window    <= 1'b0;
         overrun       <= 1'b0;
         spurious_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         busy      <= (state_nxt != ST_IDLE);
         scaler_go <= (state == ST_CLEAR) && clr_done;
         p2c_go    <= p2c_fire;

         if (state == ST_IDLE) begin
            // Pending frame wins; a same-cycle new frame refills the slot
            if (pending) begin
               cur_win <= pend_win;
               pending <= frame_valid;
               if (frame_valid) pend_win <= frame_window;
            end else if (frame_valid) begin
               cur_win <= frame_window;
            end
            if (clr_start)
               scale_amt <= (scale_amt_in == '0) ? DEFAULT_SCALE : scale_amt_in;
         end else if (frame_valid && !pending) begin
            pending  <= 1'b1;
            pend_win <= frame_window;
         end

         if (drop) overrun <= 1'b1;
         if ((state == ST_CLEAR) && clr_done) scaler_window <= cur_win;
         if (p2c_fire) p2c_window <= cur_win;
         if (scaler_done && (state != ST_BUSY)) spurious_done <= 1'b1;
      end
   end

`ifdef PV_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frames_done_cnt    <= '0;
         frames_dropped_cnt <= '0;
      end else begin
         if (p2c_go) frames_done_cnt    <= pv_sat_inc16(frames_done_cnt);
         if (drop)   frames_dropped_cnt <= pv_sat_inc16(frames_dropped_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_pv_frame_scheduler.sv
// Directed bench for pv_frame_scheduler; expected values are hand-derived cycle counts.
module tb_pv_frame_scheduler;
   import pv_pkg::*;

   localparam int NBINS  = 2048;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              frame_valid = 1'b0;
   logic              frame_window = 1'b0;
   logic [DATA_W-1:0] scale_amt_in = '0;
   logic              scaler_done = 1'b0;
   logic              p2c_ready = 1'b0;
   logic              scaler_go, scaler_window, p2c_go, p2c_window;
   logic [DATA_W-1:0] scale_amt;
   logic [ADDR_W-1:0] clr_wraddr;
   logic              clr_wren, busy, overrun, spurious_done;
`ifdef PV_SCHED_STATS_EN
   logic [15:0]       frames_done_cnt, frames_dropped_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int sgo_cnt = 0;
   int p2c_cnt = 0;

   pv_frame_scheduler dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .frame_valid  (frame_valid),
      .frame_window (frame_window),
      .scale_amt_in (scale_amt_in),
      .scaler_go    (scaler_go),
      .scaler_window(scaler_window),
      .scale_amt    (scale_amt),
      .scaler_done  (scaler_done),
      .p2c_ready    (p2c_ready),
      .p2c_go       (p2c_go),
      .p2c_window   (p2c_window),
      .clr_wraddr   (clr_wraddr),
      .clr_wren     (clr_wren),
      .busy         (busy),
      .overrun      (overrun),
      .spurious_done(spurious_done)
`ifdef PV_SCHED_STATS_EN
      ,
      .frames_done_cnt   (frames_done_cnt),
      .frames_dropped_cnt(frames_dropped_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (scaler_go) sgo_cnt++;
      if (p2c_go)    p2c_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame(input logic win, input logic [DATA_W-1:0] scl);
      frame_window = win;
      scale_amt_in = scl;
      frame_valid  = 1'b1;
      tick;
      frame_valid  = 1'b0;
   endtask

   task automatic wait_sgo(input string tag);
      int n = 0;
      while (!scaler_go && n < NBINS + 20) begin
         tick;
         n++;
      end
      chk(tag, 32'(scaler_go), 32'd1);
   endtask

   task automatic done_pulse;
      scaler_done = 1'b1;
      tick;
      scaler_done = 1'b0;
   endtask

   initial begin
      int cyc, nwr, aerr, n, s0, p0;

      // reset state
      repeat (3) tick;
      chk("rst_busy",     32'(busy), 0);
      chk("rst_wren",     32'(clr_wren), 0);
      chk("rst_addr",     32'(clr_wraddr), 0);
      chk("rst_sgo",      32'(scaler_go), 0);
      chk("rst_p2c",      32'(p2c_go), 0);
      chk("rst_scale",    32'(scale_amt), 32'h0100);
      chk("rst_overrun",  32'(overrun), 0);
      chk("rst_spurious", 32'(spurious_done), 0);
      reset_n = 1'b1;
      tick;

      // single frame, window 1, scale 0x0180
      p2c_ready = 1'b1;
      pulse_frame(1'b1, 16'h0180);
      cyc = 1; nwr = 0; aerr = 0;
      chk("t1_busy_c1", 32'(busy), 1);
      while (clr_wren && nwr < NBINS + 5) begin
         if (32'(clr_wraddr) != 32'(nwr)) aerr++;
         nwr++;
         tick;
         cyc++;
      end
      chk("t1_clr_count", 32'(nwr), NBINS);
      chk("t1_clr_addr_errs", 32'(aerr), 0);
      chk("t1_go_cycle", 32'(cyc), NBINS + 1);
      chk("t1_sgo", 32'(scaler_go), 1);
      chk("t1_swin", 32'(scaler_window), 1);
      chk("t1_scale", 32'(scale_amt), 32'h0180);
      tick;
      chk("t1_sgo_one", 32'(scaler_go), 0);
      p0 = p2c_cnt;
      repeat (99) tick;
      done_pulse;
      chk("t1_p2c_early", 32'(p2c_cnt - p0), 0);
      chk("t1_p2c_go", 32'(p2c_go), 1);
      chk("t1_p2c_win", 32'(p2c_window), 1);
      chk("t1_busy_go", 32'(busy), 1);
      tick;
      chk("t1_p2c_one", 32'(p2c_go), 0);
      chk("t1_idle", 32'(busy), 0);

      // zero scale substitutes unity; scale held while busy
      pulse_frame(1'b0, 16'h0000);
      wait_sgo("t2_sgo");
      chk("t2_scale_dflt", 32'(scale_amt), 32'h0100);
      chk("t2_swin", 32'(scaler_window), 0);
      scale_amt_in = 16'h1234;
      repeat (20) tick;
      chk("t2_scale_hold", 32'(scale_amt), 32'h0100);
      done_pulse;
      chk("t2_p2c_go", 32'(p2c_go), 1);
      chk("t2_p2c_win", 32'(p2c_window), 0);
      tick;

      // back-pressure: ready rises 50 cycles after scaler_done
      p2c_ready = 1'b0;
      pulse_frame(1'b1, 16'h0200);
      wait_sgo("t3_sgo");
      repeat (5) tick;
      done_pulse;
      p0 = p2c_cnt;
      repeat (49) tick;
      chk("t3_drain_busy", 32'(busy), 1);
      chk("t3_no_go", 32'(p2c_cnt - p0), 0);
      p2c_ready = 1'b1;
      tick;
      chk("t3_p2c_go", 32'(p2c_go), 1);
      chk("t3_p2c_win", 32'(p2c_window), 1);
      tick;
      chk("t3_idle", 32'(busy), 0);
      repeat (3) tick;
      chk("t3_single_go", 32'(p2c_cnt - p0), 1);

      // spurious done in IDLE
      p0 = p2c_cnt;
      done_pulse;
      chk("t4_spurious", 32'(spurious_done), 1);
      chk("t4_busy", 32'(busy), 0);
      repeat (3) tick;
      chk("t4_no_clear", 32'(clr_wren), 0);
      chk("t4_no_p2c", 32'(p2c_cnt - p0), 0);

      // reset at clear address 1000
      pulse_frame(1'b0, 16'h0200);
      n = 0;
      while (32'(clr_wraddr) != 32'd1000 && n < NBINS) begin
         tick;
         n++;
      end
      chk("t5_at_1000", 32'(clr_wraddr), 1000);
      reset_n = 1'b0;
      tick;
      chk("t5_wren_off", 32'(clr_wren), 0);
      chk("t5_addr0", 32'(clr_wraddr), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_scale", 32'(scale_amt), 32'h0100);
      chk("t5_spur_clr", 32'(spurious_done), 0);
      reset_n = 1'b1;
      s0 = sgo_cnt; p0 = p2c_cnt;
      repeat (NBINS + 50) tick;
      chk("t5_no_sgo", 32'(sgo_cnt - s0), 0);
      chk("t5_no_p2c", 32'(p2c_cnt - p0), 0);
      pulse_frame(1'b1, 16'h0300);
      chk("t5_restart_wren", 32'(clr_wren), 1);
      chk("t5_restart_addr", 32'(clr_wraddr), 0);
      tick;
      chk("t5_restart_addr1", 32'(clr_wraddr), 1);
      reset_n = 1'b0;
      repeat (2) tick;
      reset_n = 1'b1;
      tick;

      // overrun: windows 0,1,0 ten cycles apart
      p2c_ready = 1'b1;
      pulse_frame(1'b0, 16'h0180);
      repeat (9) tick;
      pulse_frame(1'b1, 16'h0180);
      chk("t6_no_overrun", 32'(overrun), 0);
      repeat (9) tick;
      pulse_frame(1'b0, 16'h0180);
      chk("t6_overrun", 32'(overrun), 1);
      wait_sgo("t6_sgo1");
      chk("t6_swin1", 32'(scaler_window), 0);
      tick;
      done_pulse;
      chk("t6_p2c1", 32'(p2c_go), 1);
      chk("t6_p2c_win1", 32'(p2c_window), 0);
      tick;
      chk("t6_idle_gap", 32'(busy), 0);
      tick;
      chk("t6_pend_clear", 32'(clr_wren), 1);
      chk("t6_pend_addr", 32'(clr_wraddr), 0);
      wait_sgo("t6_sgo2");
      chk("t6_swin2", 32'(scaler_window), 1);
      tick;
      done_pulse;
      chk("t6_p2c2", 32'(p2c_go), 1);
      chk("t6_p2c_win2", 32'(p2c_window), 1);
      s0 = sgo_cnt;
      repeat (30) tick;
      chk("t6_no_third", 32'(sgo_cnt - s0), 0);
      chk("t6_final_idle", 32'(busy), 0);
      chk("t6_overrun_sticky", 32'(overrun), 1);
`ifdef PV_SCHED_STATS_EN
      chk("t6_frames_done", 32'(frames_done_cnt), 2);
      chk("t6_frames_dropped", 32'(frames_dropped_cnt), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
